fadd_stream_acc: RTL and testbench

//  Streaming FP accumulator that sums a burst of operands using the combinational fadd.

---
 rtl/fadd_stream_acc_if.sv | 25 ++
 rtl/fadd_stream_acc.sv | 111 +++++++++++
 tb/tb_fadd_stream_acc.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fadd_stream_acc_if.sv
// rtl/fadd_stream_acc_if.sv - input beat stream and burst result handshake bundle for fadd_stream_acc
interface fadd_stream_acc_if #(
  parameter int N  = 32,
  parameter int CW = 9
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic [CW-1:0] out_count;
  logic [2:0]   out_status;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_status
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_status
  );
endinterface

// File: rtl/fadd_stream_acc.sv
// rtl/fadd_stream_acc.sv - burst FP accumulator around an external combinational fadd
// Optional feature FACC_NAN_STOP_EN: freeze the accumulator on the first NaN so its payload is returned.
module fadd_stream_acc #(
  parameter int N       = 32,
  parameter int MAX_LEN = 256,
  parameter int CW      = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fadd_stream_acc_if.slave     bus,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  input  logic [N-1:0]         add_res
);

  localparam int EW = (N == 64) ? 11 : 8;
  localparam int MW = N - 1 - EW;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    status_q, status_d;
  logic          accept;
  logic [2:0]    beat_flags;

  function automatic logic is_nan(input logic [N-1:0] x);
    return (&x[N-2 -: EW]) && (|x[MW-1:0]);
  endfunction

  function automatic logic is_inf(input logic [N-1:0] x);
    return (&x[N-2 -: EW]) && !(|x[MW-1:0]);
  endfunction

  assign bus.in_ready   = (state_q != S_OUT);
  assign bus.out_valid  = (state_q == S_OUT);
  assign bus.out_data   = acc_q;
  assign bus.out_count  = count_q;
  assign bus.out_status = status_q;
  assign add_a          = acc_q;
  assign add_b          = bus.in_data;

  assign accept     = bus.in_valid && bus.in_ready;
  // Flags come from the operands; invalid-operation NaNs made by fadd itself are not reported.
  assign beat_flags = {is_inf(bus.in_data), is_nan(bus.in_data), 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      count_q  <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    count_d  = count_q;
    status_d = status_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          acc_d    = bus.in_data;
          count_d  = CW'(1);
          status_d = status_q | beat_flags;
          if (bus.in_last) begin
            state_d = S_OUT;
          end else if (MAX_LEN == 1) begin
            status_d[0] = 1'b1;
            state_d     = S_OUT;
          end else begin
            state_d = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (accept) begin
`ifdef FACC_NAN_STOP_EN
          acc_d = is_nan(acc_q) ? acc_q : add_res;
`else
          acc_d = add_res;
`endif
          count_d  = count_q + CW'(1);
          status_d = status_q | beat_flags;
          if (bus.in_last) begin
            state_d = S_OUT;
          end else if (count_q == CW'(MAX_LEN - 1)) begin
            status_d[0] = 1'b1;
            state_d     = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d  = S_IDLE;
          count_d  = '0;
          status_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fadd_stream_acc.sv
// tb/tb_fadd_stream_acc.sv - self-checking bench for fadd_stream_acc with a behavioural fadd
module tb_fadd_stream_acc;

  localparam int N       = 32;
  localparam int MAX_LEN = 4;
  localparam int CW      = $clog2(MAX_LEN + 1);

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] add_a, add_b, add_res;

  always #5 clk = ~clk;

  fadd_stream_acc_if #(.N(N), .CW(CW)) ifc ();

  fadd_stream_acc #(.N(N), .MAX_LEN(MAX_LEN)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc.slave),
    .add_a   (add_a),
    .add_b   (add_b),
    .add_res (add_res)
  );

  function automatic real f2r(input logic [31:0] x);
    logic [63:0] b;
    int e;
    if (x[30:23] == 8'd0) return 0.0;
    e = int'(x[30:23]) + 896;
    b = {x[31], e[10:0], x[22:0], 29'd0};
    return $bitstoreal(b);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] b;
    int e;
    if (r == 0.0) return 32'h0;
    b = $realtobits(r);
    e = int'(b[62:52]) - 896;
    return {b[63], e[7:0], b[51:29]};
  endfunction

  // Operands limited to zero, normals, Inf and NaN; any NaN result is all-ones.
  function automatic logic [31:0] fadd_model(input logic [31:0] a, input logic [31:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    a_inf = (&a[30:23]) && !(|a[22:0]);
    b_inf = (&b[30:23]) && !(|b[22:0]);
    if (a_nan || b_nan) return 32'hFFFF_FFFF;
    if (a_inf && b_inf) return (a[31] != b[31]) ? 32'hFFFF_FFFF : a;
    if (a_inf) return a;
    if (b_inf) return b;
    return r2f(f2r(a) + f2r(b));
  endfunction

  always_comb add_res = fadd_model(add_a, add_b);

  typedef struct {
    logic [31:0] data;
    int          count;
    logic [2:0]  status;
  } exp_t;

  typedef struct {
    logic [3:0][31:0] beats;
    int               nb;
    exp_t             res;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ifc.out_valid && ifc.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'(ifc.out_data), 64'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 64'(ifc.out_data), 64'(e.data));
        chk("out_count", 64'(ifc.out_count), 64'(e.count));
        chk("out_status", 64'(ifc.out_status), 64'(e.status));
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    ifc.in_last  = l;
    @(negedge clk);
    while (!ifc.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("in_ready_timeout", 64'(guard), 64'd0);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int nb, input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [31:0] b3,
                              input logic [31:0] d, input int c, input logic [2:0] s);
    vec_t v;
    v.beats = {b3, b2, b1, b0};
    v.nb    = nb;
    v.res   = '{data: d, count: c, status: s};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] nan_exp;
    logic [31:0] held;
`ifdef FACC_NAN_STOP_EN
    nan_exp = 32'h7FC0_0000;
`else
    nan_exp = 32'hFFFF_FFFF;
`endif
    vecs[0] = mk(3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h0, 32'h40C00000, 3, 3'b000);
    vecs[1] = mk(1, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h3F800000, 1, 3'b000);
    vecs[2] = mk(4, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40800000, 4, 3'b000);
    vecs[3] = mk(2, 32'h7F800000, 32'hFF800000, 32'h0, 32'h0, 32'hFFFFFFFF, 2, 3'b100);
    vecs[4] = mk(2, 32'h7FC00000, 32'h3F800000, 32'h0, 32'h0, nan_exp, 2, 3'b010);
    vecs[5] = mk(2, 32'h40000000, 32'hC0000000, 32'h0, 32'h0, 32'h00000000, 2, 3'b000);
    vecs[6] = mk(2, 32'h3F800000, 32'h7F800000, 32'h0, 32'h0, 32'h7F800000, 2, 3'b100);

    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.in_last   = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("rst_out_data", 64'(ifc.out_data), 64'd0);
    chk("rst_out_count", 64'(ifc.out_count), 64'd0);
    chk("rst_out_status", 64'(ifc.out_status), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      sb.push_back(vecs[i].res);
      for (int j = 0; j < vecs[i].nb; j++) send(vecs[i].beats[j], j == vecs[i].nb - 1);
      drain();
    end

    // single beat: sum visible one cycle after acceptance
    ifc.out_ready = 1'b0;
    send(32'h40400000, 1'b1);
    chk("lat_out_valid", 64'(ifc.out_valid), 64'd1);
    chk("lat_in_ready", 64'(ifc.in_ready), 64'd0);
    chk("lat_out_data", 64'(ifc.out_data), 64'h40400000);
    sb.push_back('{data: 32'h40400000, count: 1, status: 3'b000});
    ifc.out_ready = 1'b1;
    drain();

    // MAX_LEN truncation, then the remainder forms a new burst
    sb.push_back('{data: 32'h40800000, count: 4, status: 3'b001});
    sb.push_back('{data: 32'h40000000, count: 2, status: 3'b000});
    for (int j = 0; j < 6; j++) send(32'h3F800000, j == 5);
    drain();

    // back-pressure on the result with a pending beat offered during OUT
    ifc.out_ready = 1'b0;
    send(32'h3F800000, 1'b0);
    send(32'h40000000, 1'b1);
    held = ifc.out_data;
    chk("hold_first", 64'(held), 64'h40400000);
    ifc.in_valid = 1'b1;
    ifc.in_data  = 32'h41000000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 64'(ifc.out_valid), 64'd1);
      chk("hold_data", 64'(ifc.out_data), 64'(held));
      chk("hold_count", 64'(ifc.out_count), 64'd2);
      chk("hold_in_ready", 64'(ifc.in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    sb.push_back('{data: 32'h40400000, count: 2, status: 3'b000});
    ifc.out_ready = 1'b1;
    drain();

    // reset mid-burst: partial sum discarded
    send(32'h3F800000, 1'b0);
    send(32'h3F800000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(ifc.in_ready), 64'd1);
    chk("abort_out_valid", 64'(ifc.out_valid), 64'd0);
    chk("abort_count", 64'(ifc.out_count), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.push_back('{data: 32'h40800000, count: 1, status: 3'b000});
    send(32'h40800000, 1'b1);
    drain();

    // reset while holding a result
    ifc.out_ready = 1'b0;
    send(32'h40000000, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid2", 64'(ifc.out_valid), 64'd0);
    chk("abort_out_data2", 64'(ifc.out_data), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_abort_idle", 64'(ifc.out_valid), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
